// File: rtl/aes_v2_sub_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : aes_v2_sub_arbiter
// Purpose : Shares one external AES S-box between two requesters (port 0 =
//           SubBytes instruction path, port 1 = key-schedule path). Each
//           granted request performs four byte lookups, assembles a 32-bit
//           word and returns it with a one-cycle ready pulse.
// Revision: 1.0 - initial release
//
// Parameters
//   FIXED_PRIO : 1 = port 0 wins ties, 0 = round-robin between ports
//
// Ports
//   g_clk, g_resetn        : clock, synchronous active-low reset
//   reqN_valid             : request (held with inputs stable until reqN_ready)
//   reqN_din  [31:0]       : input word, byte i = din[8i+7:8i]
//   reqN_enc               : 1 = forward S-box, 0 = inverse
//   reqN_rot               : rotate the assembled result
//   reqN_ready             : one-cycle result-valid pulse
//   rd        [31:0]       : shared result word, valid while a ready is high
//   busy                   : a request is in progress (state != IDLE)
//   grant                  : id of the current or last granted port
//   sbox_in   [7:0]        : byte to the S-box (0 when no lookup is active)
//   sbox_inv               : inverse select to the S-box (!enc of granted port)
//   sbox_out  [7:0]        : combinational S-box result
//------------------------------------------------------------------------------
module aes_v2_sub_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req0_valid,
  input  logic [31:0] req0_din,
  input  logic        req0_enc,
  input  logic        req0_rot,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_din,
  input  logic        req1_enc,
  input  logic        req1_rot,
  output logic        req1_ready,
  output logic [31:0] rd,
  output logic        busy,
  output logic        grant,
  output logic [7:0]  sbox_in,
  output logic        sbox_inv,
  input  logic [7:0]  sbox_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;
  logic [7:0]  r_b2;
  logic [31:0] r_rd;
  logic        r_ready0;
  logic        r_ready1;
  logic        r_grant;
  logic        r_ptr;

  logic        w_any_valid;
  logic        w_winner;
  logic        w_sel;
  logic        w_sel_valid;
  logic [31:0] w_sel_din;
  logic        w_sel_enc;
  logic        w_sel_rot;
  logic        w_lookup;
  logic [1:0]  w_idx;

  assign w_any_valid = req0_valid | req1_valid;

  // Tie-break: pointer in round-robin mode, port 0 in fixed mode. With a single
  // valid the winner is simply that port (port 0 when neither is valid).
  always_comb begin
    w_winner = req1_valid;
    if (req0_valid && req1_valid) begin
      w_winner = (FIXED_PRIO != 0) ? 1'b0 : r_ptr;
    end
  end

  // In IDLE the lookup uses the port about to be granted; afterwards the
  // registered grant selects the port.
  assign w_sel       = (r_state == ST_IDLE) ? w_winner : r_grant;
  assign w_sel_valid = w_sel ? req1_valid : req0_valid;
  assign w_sel_din   = w_sel ? req1_din   : req0_din;
  assign w_sel_enc   = w_sel ? req1_enc   : req0_enc;
  assign w_sel_rot   = w_sel ? req1_rot   : req0_rot;

  // A withdrawn request in BUSY performs no lookup that cycle.
  assign w_lookup = ((r_state == ST_IDLE) || (r_state == ST_BUSY)) && w_sel_valid;
  assign w_idx    = (r_state == ST_BUSY) ? r_cnt : 2'd0;

  assign sbox_in  = w_lookup ? w_sel_din[{w_idx, 3'b000} +: 8] : 8'h00;
  assign sbox_inv = w_lookup ? ~w_sel_enc : 1'b0;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 2'd0;
      r_b0     <= 8'h00;
      r_b1     <= 8'h00;
      r_b2     <= 8'h00;
      r_rd     <= 32'h0;
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      r_grant  <= 1'b0;
      r_ptr    <= 1'b0;
    end else begin
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant <= w_winner;
            r_b0    <= sbox_out;
            r_cnt   <= 2'd1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!w_sel_valid) begin
            // Abort: no result, pointer and rd untouched.
            r_cnt   <= 2'd0;
            r_state <= ST_IDLE;
          end else begin
            case (r_cnt)
              2'd1:    r_b1 <= sbox_out;
              2'd2:    r_b2 <= sbox_out;
              default: ;
            endcase
            if (r_cnt == 2'd3) begin
              r_rd     <= w_sel_rot ? {r_b2, r_b1, r_b0, sbox_out}
                                    : {sbox_out, r_b2, r_b1, r_b0};
              r_ready0 <= ~r_grant;
              r_ready1 <= r_grant;
              r_state  <= ST_DONE;
            end
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          r_ptr   <= ~r_grant;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = r_ready0;
  assign req1_ready = r_ready1;
  assign rd         = r_rd;
  assign busy       = (r_state != ST_IDLE);
  assign grant      = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_aes_v2_sub_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : tb_aes_v2_sub_arbiter
// Purpose : Self-checking bench for aes_v2_sub_arbiter. Two instances share the
//           request stimulus: one round-robin, one fixed-priority. Each has its
//           own S-box model and its own queue of expected results.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_aes_v2_sub_arbiter;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic        g_clk      = 1'b0;
  logic        g_resetn   = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_din   = 32'h0;
  logic        req0_enc   = 1'b0;
  logic        req0_rot   = 1'b0;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_din   = 32'h0;
  logic        req1_enc   = 1'b0;
  logic        req1_rot   = 1'b0;

  logic        rr_rdy0, rr_rdy1, rr_busy, rr_grant, rr_sinv;
  logic [31:0] rr_rd;
  logic [7:0]  rr_sin, rr_sout;
  logic        fp_rdy0, fp_rdy1, fp_busy, fp_grant, fp_sinv;
  logic [31:0] fp_rd;
  logic [7:0]  fp_sin, fp_sout;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q_rr[$];
  exp_t q_fp[$];
  exp_t e;

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  assign rr_sout = rr_sinv ? isb[rr_sin] : sb[rr_sin];
  assign fp_sout = fp_sinv ? isb[fp_sin] : sb[fp_sin];

  aes_v2_sub_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req0_valid(req0_valid), .req0_din(req0_din), .req0_enc(req0_enc),
    .req0_rot(req0_rot), .req0_ready(rr_rdy0),
    .req1_valid(req1_valid), .req1_din(req1_din), .req1_enc(req1_enc),
    .req1_rot(req1_rot), .req1_ready(rr_rdy1),
    .rd(rr_rd), .busy(rr_busy), .grant(rr_grant),
    .sbox_in(rr_sin), .sbox_inv(rr_sinv), .sbox_out(rr_sout)
  );

  aes_v2_sub_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req0_valid(req0_valid), .req0_din(req0_din), .req0_enc(req0_enc),
    .req0_rot(req0_rot), .req0_ready(fp_rdy0),
    .req1_valid(req1_valid), .req1_din(req1_din), .req1_enc(req1_enc),
    .req1_rot(req1_rot), .req1_ready(fp_rdy1),
    .rd(fp_rd), .busy(fp_busy), .grant(fp_grant),
    .sbox_in(fp_sin), .sbox_inv(fp_sinv), .sbox_out(fp_sout)
  );

  // Reference result of one request.
  function automatic logic [31:0] model(input logic [31:0] din, input logic enc,
                                        input logic rot);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = enc ? sb[din[8*i +: 8]] : isb[din[8*i +: 8]];
    return rot ? {b[2], b[1], b[0], b[3]} : {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_both(input bit p, input logic [31:0] d, input int c);
    exp_t x;
    x.port = p; x.data = d; x.cyc = c;
    q_rr.push_back(x);
    q_fp.push_back(x);
  endtask

  // Single-port request: checks every lookup byte, then releases in DONE.
  task automatic single(input bit p, input logic [31:0] din, input logic enc,
                        input logic rot, input logic [31:0] expd);
    if (p) begin
      req1_valid = 1'b1; req1_din = din; req1_enc = enc; req1_rot = rot;
    end else begin
      req0_valid = 1'b1; req0_din = din; req0_enc = enc; req0_rot = rot;
    end
    push_both(p, expd, cyc + 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sbox_in", {56'h0, rr_sin}, {56'h0, din[8*i +: 8]});
      chk("sbox_inv", {63'h0, rr_sinv}, {63'h0, ~enc});
      step();
    end
    chk("busy_in_done", {63'h0, rr_busy}, 64'h1);
    chk("grant", {63'h0, rr_grant}, {63'h0, p});
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  // Result monitors: every ready pulse must match the head of its queue,
  // including the cycle it was due.
  always @(negedge g_clk) begin
    if (rr_rdy0 || rr_rdy1) begin
      n_cmp++;
      assert (q_rr.size() != 0) else begin
        n_fail++;
        $error("FAIL rr_unexpected_ready observed=%b%b expected=none", rr_rdy1, rr_rdy0);
      end
      if (q_rr.size() != 0) begin
        e = q_rr.pop_front();
        n_cmp++;
        assert (({rr_rdy1, rr_rdy0, rr_rd} === {e.port, ~e.port, e.data}) && (cyc == e.cyc)) else begin
          n_fail++;
          $error("FAIL rr_result observed=rdy%b%b rd=%h cyc=%0d expected=rdy%b%b rd=%h cyc=%0d",
                 rr_rdy1, rr_rdy0, rr_rd, cyc, e.port, ~e.port, e.data, e.cyc);
        end
      end
    end
    if (fp_rdy0 || fp_rdy1) begin
      n_cmp++;
      assert (q_fp.size() != 0) else begin
        n_fail++;
        $error("FAIL fp_unexpected_ready observed=%b%b expected=none", fp_rdy1, fp_rdy0);
      end
      if (q_fp.size() != 0) begin
        e = q_fp.pop_front();
        n_cmp++;
        assert (({fp_rdy1, fp_rdy0, fp_rd} === {e.port, ~e.port, e.data}) && (cyc == e.cyc)) else begin
          n_fail++;
          $error("FAIL fp_result observed=rdy%b%b rd=%h cyc=%0d expected=rdy%b%b rd=%h cyc=%0d",
                 fp_rdy1, fp_rdy0, fp_rd, cyc, e.port, ~e.port, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b, c, d, ma, mb, md;
    int          t;
    bit          p;

    for (int i = 0; i < 256; i++) sb[i] = SBOX[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    // Reset, then idle with no requests.
    repeat (3) step();
    g_resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rr", {19'h0, rr_busy, rr_rdy0, rr_rdy1, rr_grant, rr_sinv, rr_sin, rr_rd}, 64'h0);
      chk("idle_fp", {19'h0, fp_busy, fp_rdy0, fp_rdy1, fp_grant, fp_sinv, fp_sin, fp_rd}, 64'h0);
    end

    // Known-answer single-port requests.
    single(1'b0, 32'h03020100, 1'b1, 1'b0, 32'h7b777c63);
    single(1'b0, 32'h03020100, 1'b1, 1'b1, 32'h777c637b);
    for (int i = 0; i < 4; i++) begin
      p = 1'($urandom_range(0, 1));
      a = $urandom;
      c = $urandom;
      single(p, a, c[0], c[1], model(a, c[0], c[1]));
    end
    // Served last so the round-robin pointer points at port 0 afterwards.
    single(1'b1, 32'h7b777c63, 1'b0, 1'b0, 32'h03020100);

    // Both ports held for four services: round-robin alternates, fixed
    // priority serves port 0 every time.
    a = $urandom;
    b = $urandom;
    ma = model(a, 1'b1, 1'b0);
    mb = model(b, 1'b0, 1'b1);
    req0_valid = 1'b1; req0_din = a; req0_enc = 1'b1; req0_rot = 1'b0;
    req1_valid = 1'b1; req1_din = b; req1_enc = 1'b0; req1_rot = 1'b1;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      e.port = 1'(k % 2); e.data = (k % 2 == 0) ? ma : mb; e.cyc = t + 4 + 5*k;
      q_rr.push_back(e);
      e.port = 1'b0; e.data = ma;
      q_fp.push_back(e);
    end
    step();
    chk("both_grant_rr_first", {63'h0, rr_grant}, 64'h0);
    chk("both_grant_fp_first", {63'h0, fp_grant}, 64'h0);
    repeat (5) step();
    chk("both_grant_rr_second", {63'h0, rr_grant}, 64'h1);
    chk("both_grant_fp_second", {63'h0, fp_grant}, 64'h0);
    repeat (13) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Port 0 withdraws at cnt=2 while port 1 waits.
    c = $urandom;
    d = $urandom;
    md = model(d, 1'b1, 1'b0);
    req0_valid = 1'b1; req0_din = c; req0_enc = 1'b1; req0_rot = 1'b1;
    req1_valid = 1'b1; req1_din = d; req1_enc = 1'b1; req1_rot = 1'b0;
    step();
    step();
    req0_valid = 1'b0;
    #1;
    chk("abort_sbox_in", {56'h0, rr_sin}, 64'h0);
    step();
    chk("abort_busy", {63'h0, rr_busy}, 64'h0);
    chk("abort_rd_kept", {32'h0, rr_rd}, {32'h0, mb});
    chk("abort_next_lookup", {56'h0, rr_sin}, {56'h0, d[7:0]});
    push_both(1'b1, md, cyc + 4);
    step();
    chk("abort_grant_rr", {63'h0, rr_grant}, 64'h1);
    chk("abort_grant_fp", {63'h0, fp_grant}, 64'h1);
    repeat (3) step();
    req1_valid = 1'b0;
    step();

    // Reset in the middle of BUSY.
    req0_valid = 1'b1; req0_din = $urandom; req0_enc = 1'b1; req0_rot = 1'b0;
    step();
    step();
    g_resetn = 1'b0;
    step();
    g_resetn = 1'b1;
    req0_valid = 1'b0;
    #1;
    chk("midreset_rr", {30'h0, rr_busy, rr_rdy0, rr_rd}, 64'h0);
    chk("midreset_fp", {30'h0, fp_busy, fp_rdy0, fp_rd}, 64'h0);
    repeat (6) step();
    chk("midreset_idle", {62'h0, rr_busy, fp_busy}, 64'h0);

    // Every expected result must have been delivered.
    chk("rr_pending", 64'(q_rr.size()), 64'h0);
    chk("fp_pending", 64'(q_fp.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
